regfile_dbg_port: RTL and testbench
===================================

Name:
regfile_dbg_port

Overview:
- Debug access initiator for the RV32I register file. Accepts read, write and dump commands over a valid/ready command channel, halts the core, and drives the regfile's second read port and write port while the core is halted.
- Returns results over a valid/ready response channel and then releases the core. Sits between the debug transport and the regfile/core stall logic.

Parameters:
HALT_TIMEOUT, 255, max cycles to wait for halt_ack (used only with DBG_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_dump  input  1  1 = dump x0..x31 (overrides cmd_write)
cmd_addr  input  5  register index for read/write
cmd_wdata  input  32  write data
rsp_valid  output  1  response valid, held until rsp_ready
rsp_ready  input  1  response consumer ready
rsp_data  output  32  read data, or echoed write data
rsp_addr  output  5  register index of this response
rsp_last  output  1  final response of a command (always 1 for read/write)
rsp_err  output  1  halt timeout error (0 without DBG_TIMEOUT_EN)
halt_req  output  1  stall request to core
halt_ack  input  1  core is halted, regfile ports free
rf_addr  output  5  drives regfile read address and rd_addr
rf_rdata  input  32  regfile combinational read data
rf_we  output  1  regfile write_enable
rf_wdata  output  32  regfile rd_wdata

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1. rst mid-operation aborts on that edge: halt_req, rsp_valid and rf_we drop to 0 and no regfile write occurs.
- States: IDLE, HALT_WAIT, ACCESS, RSP, RELEASE.
- IDLE: cmd_ready=1 (only here). On handshake at edge N, latch write/dump/addr/wdata, set halt_req=1, go to HALT_WAIT. For dump the address counter is cleared to 0.
- HALT_WAIT: hold halt_req=1. halt_ack=1 sampled at an edge -> ACCESS.
- ACCESS (exactly 1 cycle): rf_addr = latched address/counter.
  - Write: rf_we=1 and rf_wdata=wdata, except when addr==0, where rf_we stays 0. rsp_data=wdata.
  - Read/dump: rsp_data captures rf_rdata at the end of the cycle.
  - Next state: RSP.
- RSP: rsp_valid=1 with rsp_data/rsp_addr/rsp_last stable until rsp_ready. On handshake:
  - Dump with addr<31: counter+1, go to ACCESS; halt_req stays high.
  - Otherwise: go to RELEASE.
- rsp_last=1 for read/write and for the dump response at addr 31; 0 for dump addresses 0..30.
- RELEASE: halt_req=0; wait for halt_ack==0, then IDLE. This prevents a new halt overlapping the old ack.
- Latency: with halt_ack already high, rsp_valid rises at cycle N+3 after the accept edge N. A dump costs 1 ACCESS + 1 RSP cycle per register when rsp_ready is held high.
- A read of x0 returns rf_rdata (0 by regfile). Write to x0 completes normally with the wdata echo, but the regfile is not written.
- rf_we is never asserted outside ACCESS. halt_req is continuous from the accept edge until RELEASE.

Optional Feature:
DBG_TIMEOUT_EN
- Defined: a HALT_WAIT counter (8 bits minimum, sized for HALT_TIMEOUT). If halt_ack is not seen within HALT_TIMEOUT cycles, go to RSP with rsp_err=1, rsp_data=0, rsp_last=1, and skip ACCESS.
- Undefined: HALT_WAIT waits indefinitely; rsp_err is constant 0; no counter.

Test Plan:
- Read: regfile x5=0xDEADBEEF, halt_ack tied 1, cmd read addr 5 -> rsp_valid at N+3 with rsp_data=0xDEADBEEF, rsp_addr=5, rsp_last=1; halt_req falls after the response handshake.
- Write: cmd write addr 7 data 0x12345678 -> rf_we high exactly 1 cycle with rf_addr=7; a subsequent read of 7 returns 0x12345678.
- x0 write: cmd write addr 0 data 0xFFFFFFFF -> rf_we never 1, rsp_data=0xFFFFFFFF; a subsequent read of addr 0 returns 0.
- Dump with backpressure: xi=i*3, rsp_ready toggling -> 32 responses, addrs 0..31 in order, data i*3, rsp_last only on 31, data stable while stalled.
- Halt handshake: halt_ack delayed 10 cycles, then a second command issued while halt_ack is still high after RELEASE -> no ACCESS before halt_ack, and cmd_ready=0 until halt_ack drops.
- Reset mid-dump at addr 12 -> next cycle halt_req=0, rsp_valid=0, cmd_ready=1; with DBG_TIMEOUT_EN, halt_ack held 0 -> rsp_err=1 after 255 cycles.

Source files
------------

// File: rtl/regfile_dbg_port.sv
// rtl/regfile_dbg_port.sv - debug read/write/dump initiator for the RV32I register file (optional DBG_TIMEOUT_EN)
module regfile_dbg_port #(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_dump,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_addr,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        halt_req,
    input  logic        halt_ack,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [31:0] rf_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_ACCESS,
        S_RSP,
        S_RELEASE
    } state_t;

    state_t      state, state_nxt;
    logic        lat_write;
    logic        lat_dump;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        timeout_hit;
    logic        err_flag;
    logic        dump_more;

`ifdef DBG_TIMEOUT_EN
    localparam int TW = ($clog2(HALT_TIMEOUT + 1) > 8) ? $clog2(HALT_TIMEOUT + 1) : 8;

    logic [TW-1:0] wait_cnt;
    logic          err_q;

    assign timeout_hit = (state == S_HALT_WAIT) && !halt_ack
                         && (wait_cnt == TW'(HALT_TIMEOUT - 1));
    assign err_flag    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == S_IDLE && cmd_valid) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == S_HALT_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_halt_timeout;

    assign unused_halt_timeout = ^HALT_TIMEOUT;
    assign timeout_hit         = 1'b0;
    assign err_flag            = 1'b0;
`endif

    // a timed-out dump must not walk on to the next register
    assign dump_more = lat_dump && (addr_q != 5'd31) && !err_flag;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (cmd_valid) state_nxt = S_HALT_WAIT;
            S_HALT_WAIT: begin
                if (halt_ack)
                    state_nxt = S_ACCESS;
                else if (timeout_hit)
                    state_nxt = S_RSP;
            end
            S_ACCESS:    state_nxt = S_RSP;
            S_RSP:       if (rsp_ready) state_nxt = dump_more ? S_ACCESS : S_RELEASE;
            S_RELEASE:   if (!halt_ack) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write <= 1'b0;
            lat_dump  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        lat_dump  <= cmd_dump;
                        lat_write <= cmd_write && !cmd_dump;
                        addr_q    <= cmd_dump ? 5'd0 : cmd_addr;
                        wdata_q   <= cmd_wdata;
                    end
                end
                S_HALT_WAIT: if (timeout_hit) rdata_q <= '0;
                S_ACCESS:    rdata_q <= lat_write ? wdata_q : rf_rdata;
                S_RSP:       if (rsp_ready && dump_more) addr_q <= addr_q + 5'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        halt_req  = (state == S_HALT_WAIT) || (state == S_ACCESS) || (state == S_RSP);
        rsp_valid = (state == S_RSP);
        rsp_data  = rsp_valid ? rdata_q : 32'd0;
        rsp_addr  = rsp_valid ? addr_q : 5'd0;
        rsp_last  = rsp_valid && (!lat_dump || addr_q == 5'd31 || err_flag);
        rsp_err   = rsp_valid && err_flag;
        rf_addr   = (state == S_ACCESS) ? addr_q : 5'd0;
        // x0 writes still echo data but never touch the regfile
        rf_we     = (state == S_ACCESS) && lat_write && (addr_q != 5'd0);
        rf_wdata  = (state == S_ACCESS) ? wdata_q : 32'd0;
    end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// tb/tb_regfile_dbg_port.sv - self-checking bench for regfile_dbg_port
module tb_regfile_dbg_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_dump;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_addr;
    logic        halt_req, halt_ack;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata, rf_wdata;
    logic        rf_we;

    logic        ack_auto, ack_manual;
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] rf [32];
    int          we_count = 0;
    logic [4:0]  we_addr = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    regfile_dbg_port dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_dump(cmd_dump), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata)
    );

    // core model: either acks instantly (already halted) or under manual control
    assign halt_ack = ack_auto ? halt_req : ack_manual;
    assign rf_rdata = (rf_addr == 5'd0) ? 32'd0 : rf[rf_addr];

    always @(posedge clk) begin
        if (pre_we)
            rf[pre_addr] <= pre_data;
        else if (rf_we && rf_addr != 5'd0)
            rf[rf_addr] <= rf_wdata;
        if (rf_we) begin
            we_count <= we_count + 1;
            we_addr  <= rf_addr;
        end
    end

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_we;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic rf_poke(input logic [4:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // returns at the negedge right after the accept edge
    task automatic issue(input logic wr, input logic dmp, input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        cmd_write = wr;
        cmd_dump  = dmp;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int lat;
        int w0;
        int idx;
        int cyc;
        logic bad;

        vecs[0] = '{1'b0, 5'd5,  32'h0,        32'hDEADBEEF, 0};
        vecs[1] = '{1'b1, 5'd7,  32'h12345678, 32'h12345678, 1};
        vecs[2] = '{1'b0, 5'd7,  32'h0,        32'h12345678, 0};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        32'h00000000, 0};
        vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 1};
        vecs[6] = '{1'b0, 5'd31, 32'h0,        32'hA5A5A5A5, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_dump = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        ack_auto = 1'b1; ack_manual = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_halt_req",  32'(halt_req),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_we",     32'(rf_we),     32'd0);
        check("rst_rsp_last",  32'(rsp_last),  32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        rst = 1'b0;

        rf_poke(5'd5, 32'hDEADBEEF);

        for (int v = 0; v < 7; v++) begin
            w0 = we_count;
            issue(vecs[v].wr, 1'b0, vecs[v].addr, vecs[v].wdata);
            wait_rsp(lat);
            // 2 edges after accept = response visible in cycle N+3
            check($sformatf("v%0d_latency", v),  32'(lat),      32'd2);
            check($sformatf("v%0d_rsp_data", v), rsp_data,      vecs[v].exp_data);
            check($sformatf("v%0d_rsp_addr", v), 32'(rsp_addr), 32'(vecs[v].addr));
            check($sformatf("v%0d_rsp_last", v), 32'(rsp_last), 32'd1);
            check($sformatf("v%0d_rsp_err", v),  32'(rsp_err),  32'd0);
            check($sformatf("v%0d_halt_held", v), 32'(halt_req), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_halt_drop", v), 32'(halt_req), 32'd0);
            check($sformatf("v%0d_valid_drop", v), 32'(rsp_valid), 32'd0);
            check($sformatf("v%0d_we_pulses", v), 32'(we_count - w0), 32'(vecs[v].exp_we));
            if (vecs[v].exp_we != 0)
                check($sformatf("v%0d_we_addr", v), 32'(we_addr), 32'(vecs[v].addr));
        end

        // dump with toggling backpressure
        for (int i = 1; i < 32; i++) rf_poke(5'(i), 32'(i * 3));
        w0 = we_count;
        issue(1'b0, 1'b1, 5'd0, 32'h0);
        idx = 0;
        cyc = 0;
        while (idx < 32 && cyc < 800) begin
            rsp_ready = (cyc % 3 != 1);
            if (rsp_valid) begin
                check("dump_addr", 32'(rsp_addr), 32'(idx));
                check("dump_data", rsp_data,      32'(idx * 3));
                check("dump_last", 32'(rsp_last), 32'(idx == 31));
                if (rsp_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b1;
        check("dump_count", 32'(idx), 32'd32);
        check("dump_no_we", 32'(we_count - w0), 32'd0);
        check("dump_halt_drop", 32'(halt_req), 32'd0);
        @(negedge clk);

        // delayed halt ack, then a command while the old ack is still high
        ack_auto = 1'b0;
        ack_manual = 1'b0;
        w0 = we_count;
        issue(1'b1, 1'b0, 5'd9, 32'hCAFEF00D);
        bad = 1'b0;
        repeat (10) begin
            if (rsp_valid || !halt_req || rf_we || we_count != w0) bad = 1'b1;
            @(negedge clk);
        end
        check("no_access_before_ack", 32'(bad), 32'd0);
        ack_manual = 1'b1;
        wait_rsp(lat);
        check("hs_latency", 32'(lat), 32'd2);
        check("hs_rsp_data", rsp_data, 32'hCAFEF00D);
        check("hs_we_pulses", 32'(we_count - w0), 32'd1);
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 5'd9; cmd_valid = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            if (cmd_ready || halt_req) bad = 1'b1;
            @(negedge clk);
        end
        check("ready_low_while_ack", 32'(bad), 32'd0);
        ack_manual = 1'b0;
        @(negedge clk);
        check("ready_after_ack_drop", 32'(cmd_ready), 32'd1);
        issue(1'b0, 1'b0, 5'd9, 32'h0);
        ack_manual = 1'b1;
        wait_rsp(lat);
        check("hs_read_back", rsp_data, 32'hCAFEF00D);
        @(negedge clk);
        ack_manual = 1'b0;
        ack_auto = 1'b1;
        @(negedge clk);

        // reset in the middle of a dump
        issue(1'b0, 1'b1, 5'd0, 32'h0);
        cyc = 0;
        while (!(rsp_valid && rsp_addr == 5'd12) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("dump_reached_12", 32'(rsp_addr), 32'd12);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_halt_req",  32'(halt_req),  32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_rf_we",     32'(rf_we),     32'd0);
        rst = 1'b0;
        issue(1'b0, 1'b0, 5'd12, 32'h0);
        wait_rsp(lat);
        check("post_rst_read", rsp_data, 32'd36);
        @(negedge clk);
        @(negedge clk);

`ifdef DBG_TIMEOUT_EN
        ack_auto = 1'b0;
        ack_manual = 1'b0;
        issue(1'b0, 1'b0, 5'd5, 32'h0);
        wait_rsp(lat);
        check("to_latency",  32'(lat),      32'd255);
        check("to_rsp_err",  32'(rsp_err),  32'd1);
        check("to_rsp_data", rsp_data,      32'd0);
        check("to_rsp_last", 32'(rsp_last), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("to_back_idle", 32'(cmd_ready), 32'd1);
        ack_auto = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
